// File: rtl/typeracer_pkg.sv
// Shared constants and types for the typing-game text path.
// Used by the keyboard decoder, the text buffer and the display stage.
package typeracer_pkg;

    localparam int MAX_LEN = 25;
    localparam int CHAR_W  = 5;
    localparam int TEXT_W  = MAX_LEN * CHAR_W;

    localparam logic [CHAR_W-1:0] PAD_CODE   = 5'd31;
    localparam logic [CHAR_W-1:0] LETTER_MAX = 5'd25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TYPING = 2'd1,
        DONE   = 2'd2
    } state_t;

    // A length of zero or beyond the slot count means "use every slot".
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        if (len == 5'd0 || len > 5'(MAX_LEN))
            return 5'(MAX_LEN);
        return len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count increments until full scale, clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clr_i)
            cnt_q <= '0;
        else if (inc_i && cnt_q != {WIDTH{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/typed_text_buffer.sv
// Keystroke accumulator and scorer for the typing game.
// Collects letter codes into a packed string, tracks correct positions
// against the latched target phrase and counts mistyped keys.
// Optional build macro: TYPEBUF_STRICT_EN -- mismatching letters are
// counted as errors but never stored.
module typed_text_buffer
    import typeracer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TEXT_W-1:0]   target,
    input  logic [4:0]          target_len,
    input  logic                key_valid,
    input  logic [CHAR_W-1:0]   key_code,
    input  logic                key_bs,
    input  logic                key_clr,
    output logic [TEXT_W-1:0]   text,
    output logic [4:0]          text_len,
    output logic [4:0]          correct_cnt,
    output logic [7:0]          err_cnt,
    output logic [1:0]          state,
    output logic                done
);

    localparam logic [TEXT_W-1:0] PAD_TEXT = {MAX_LEN{PAD_CODE}};

    state_t            state_q, state_d;
    logic [TEXT_W-1:0] text_q, text_d;
    logic [TEXT_W-1:0] tgt_q, tgt_d;
    logic [4:0]        len_q, len_d;
    logic [4:0]        tlen_q, tlen_d;
    logic [4:0]        corr_q, corr_d;
    logic              done_q, done_d;
    logic              err_inc, err_clr;

    // Next-state computation; only the highest-priority event acts each cycle.
    always_comb begin
        logic [CHAR_W-1:0] tgt_cur;
        logic [CHAR_W-1:0] tgt_prev;
        logic [CHAR_W-1:0] txt_prev;
        logic [4:0]        len_m1;
        logic              hit;

        state_d = state_q;
        text_d  = text_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        tlen_d  = tlen_q;
        corr_d  = corr_q;
        done_d  = 1'b0;
        err_inc = 1'b0;
        err_clr = 1'b0;

        len_m1   = len_q - 5'd1;
        tgt_cur  = tgt_q[int'(len_q) * CHAR_W +: CHAR_W];
        tgt_prev = tgt_q[int'(len_m1) * CHAR_W +: CHAR_W];
        txt_prev = text_q[int'(len_m1) * CHAR_W +: CHAR_W];
        hit      = (key_code == tgt_cur);

        if (start) begin
            state_d = TYPING;
            text_d  = PAD_TEXT;
            len_d   = 5'd0;
            corr_d  = 5'd0;
            err_clr = 1'b1;
            tgt_d   = target;
            tlen_d  = clamp_len(target_len);
        end else if (key_clr) begin
            state_d = IDLE;
            text_d  = PAD_TEXT;
            len_d   = 5'd0;
            corr_d  = 5'd0;
            err_clr = 1'b1;
        end else if (state_q == TYPING) begin
            if (key_bs) begin
                if (len_q != 5'd0) begin
                    text_d[int'(len_m1) * CHAR_W +: CHAR_W] = PAD_CODE;
                    len_d = len_m1;
                    if (txt_prev == tgt_prev)
                        corr_d = corr_q - 5'd1;
                end
            end else if (key_valid && key_code <= LETTER_MAX && len_q < tlen_q) begin
                err_inc = !hit;
`ifdef TYPEBUF_STRICT_EN
                if (hit) begin
                    text_d[int'(len_q) * CHAR_W +: CHAR_W] = key_code;
                    len_d  = len_q + 5'd1;
                    corr_d = corr_q + 5'd1;
                end
`else
                text_d[int'(len_q) * CHAR_W +: CHAR_W] = key_code;
                len_d  = len_q + 5'd1;
                corr_d = corr_q + 5'(hit);
`endif
                if (len_d == tlen_q && corr_d == tlen_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // Controller state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            text_q  <= PAD_TEXT;
            tgt_q   <= '0;
            len_q   <= 5'd0;
            tlen_q  <= 5'(MAX_LEN);
            corr_q  <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            text_q  <= text_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            tlen_q  <= tlen_d;
            corr_q  <= corr_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (err_clr),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    assign text        = text_q;
    assign text_len    = len_q;
    assign correct_cnt = corr_q;
    assign state       = state_q;
    assign done        = done_q;

endmodule

// File: tb/tb_typed_text_buffer.sv
// Self-checking bench for typed_text_buffer: directed scenarios plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_typed_text_buffer;
    import typeracer_pkg::*;

    logic         clk = 1'b0;
    logic         rst, start, key_valid, key_bs, key_clr;
    logic [124:0] target;
    logic [4:0]   target_len, key_code;
    logic [124:0] text;
    logic [4:0]   text_len, correct_cnt;
    logic [7:0]   err_cnt;
    logic [1:0]   state;
    logic         done;

    always #5 clk = ~clk;

    typed_text_buffer dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .target_len(target_len),
        .key_valid(key_valid), .key_code(key_code), .key_bs(key_bs), .key_clr(key_clr),
        .text(text), .text_len(text_len), .correct_cnt(correct_cnt), .err_cnt(err_cnt),
        .state(state), .done(done)
    );

`ifdef TYPEBUF_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [124:0] obs, input logic [124:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: typed characters as a queue, target as a plain array.
    int m_q[$];
    int m_tgt[25];
    int m_tlen  = 25;
    int m_err   = 0;
    int m_state = 0;
    bit m_done  = 0;

    function automatic int m_correct();
        int c = 0;
        foreach (m_q[i]) if (m_q[i] == m_tgt[i]) c++;
        return c;
    endfunction

    function automatic logic [124:0] m_text();
        logic [124:0] t;
        for (int i = 0; i < 25; i++)
            t[i*5 +: 5] = (i < m_q.size()) ? 5'(m_q[i]) : 5'd31;
        return t;
    endfunction

    task automatic m_err_bump();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step(input bit r, input bit s, input logic [124:0] tg, input int tl,
                              input bit kv, input int kc, input bit bs, input bit cl);
        m_done = 0;
        if (r) begin
            m_q.delete(); m_err = 0; m_state = 0; m_tlen = 25;
            foreach (m_tgt[i]) m_tgt[i] = 0;
        end else if (s) begin
            m_q.delete(); m_err = 0; m_state = 1;
            m_tlen = (tl == 0 || tl > 25) ? 25 : tl;
            foreach (m_tgt[i]) m_tgt[i] = int'(tg[i*5 +: 5]);
        end else if (cl) begin
            m_q.delete(); m_err = 0; m_state = 0;
        end else if (m_state == 1) begin
            if (bs) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
            end else if (kv && kc <= 25 && m_q.size() < m_tlen) begin
                bit match = (kc == m_tgt[m_q.size()]);
                if (!match) m_err_bump();
                if (match || !STRICT) m_q.push_back(kc);
                if (m_q.size() == m_tlen && m_correct() == m_tlen) begin
                    m_state = 2; m_done = 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input logic [124:0] tg, input logic [4:0] tl,
                       input bit kv, input logic [4:0] kc, input bit bs, input bit cl);
        rst = r; start = s; target = tg; target_len = tl;
        key_valid = kv; key_code = kc; key_bs = bs; key_clr = cl;
        @(posedge clk);
        #1;
        model_step(r, s, tg, int'(tl), kv, int'(kc), bs, cl);
        rst = 0; start = 0; key_valid = 0; key_bs = 0; key_clr = 0;
        check_eq("text", text, m_text());
        check_eq("text_len", text_len, 125'(m_q.size()));
        check_eq("correct_cnt", correct_cnt, 125'(m_correct()));
        check_eq("err_cnt", err_cnt, 125'(m_err));
        check_eq("state", state, 125'(m_state));
        check_eq("done", done, 125'(m_done));
    endtask

    logic [124:0] cur_tg;
    logic [4:0]   cur_tl;

    task automatic key(input int k);
        cyc(0, 0, cur_tg, cur_tl, 1, 5'(k), 0, 0);
    endtask
    task automatic bsp();
        cyc(0, 0, cur_tg, cur_tl, 0, 5'd0, 1, 0);
    endtask
    task automatic go();
        cyc(0, 0, cur_tg, cur_tl, 1'b0, 5'd0, 0, 0);
    endtask
    task automatic do_start();
        cyc(0, 1, cur_tg, cur_tl, 0, 5'd0, 0, 0);
    endtask

    initial begin
        rst = 1; start = 0; key_valid = 0; key_bs = 0; key_clr = 0;
        target = '0; target_len = '0; key_code = '0;
        cur_tg = '0; cur_tl = 5'd3;

        cyc(1, 0, '0, 5'd0, 0, 5'd0, 0, 0);
        cyc(1, 0, '0, 5'd0, 0, 5'd0, 0, 0);
        check_eq("reset_text", text, {25{5'd31}});
        check_eq("reset_state", state, 125'd0);

        // "CAT": straight completion
        cur_tg[4:0] = 5'd2; cur_tg[9:5] = 5'd0; cur_tg[14:10] = 5'd19; cur_tl = 5'd3;
        do_start(); key(2); key(0); key(19);
        if (!STRICT) check_eq("cat_done", done, 125'd1);
        go();
        check_eq("cat_done_drop", done, 125'd0);

        // typo, backspace, finish
        do_start(); key(2); key(1); bsp(); key(0); key(19); go();

        // full buffer with target_len 0: first letter wrong so it stays TYPING
        cur_tg = '0;
        for (int i = 0; i < 25; i++) cur_tg[i*5 +: 5] = 5'($urandom_range(0, 25));
        cur_tl = 5'd0;
        do_start();
        key((int'(cur_tg[4:0]) + 1) % 26);
        for (int i = 1; i < 25; i++) key(int'(cur_tg[i*5 +: 5]));
        key(3); key(int'(cur_tg[4:0]));

        // empty backspace, illegal code, keys in IDLE
        do_start(); bsp(); key(27); key(31);
        cyc(0, 0, cur_tg, cur_tl, 0, 5'd0, 0, 1);
        key(int'(cur_tg[4:0])); bsp();

        // start with a simultaneous key, then reset mid-typing
        cyc(0, 1, cur_tg, cur_tl, 1, cur_tg[4:0], 0, 0);
        key(int'(cur_tg[4:0])); key(int'(cur_tg[9:5]));
        cyc(1, 0, cur_tg, cur_tl, 1, cur_tg[14:10], 0, 0);
        key(1);

        // strict-mode directed case: wrong letter against 'C'
        cur_tg = '0; cur_tg[4:0] = 5'd2; cur_tl = 5'd3;
        do_start(); key(5);

        // error counter saturation
        cur_tl = 5'd25; do_start();
        for (int i = 0; i < 260; i++) begin
            key((int'(cur_tg[4:0]) + 1) % 26);
            bsp();
        end

        // randomized traffic, target bus keeps changing after start
        for (int n = 0; n < 3000; n++) begin
            int sel = $urandom_range(0, 99);
            logic [124:0] tg;
            logic [4:0] tl;
            for (int i = 0; i < 25; i++) tg[i*5 +: 5] = 5'($urandom_range(0, 25));
            tl = (n % 5 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
            if (sel < 55) begin
                int k = (m_q.size() < 25) ? m_tgt[m_q.size()] : 0;
                cyc(0, 0, tg, tl, 1, 5'(k), 0, 0);
            end else if (sel < 70) cyc(0, 0, tg, tl, 1, 5'($urandom_range(0, 31)), 0, 0);
            else if (sel < 80) cyc(0, 0, tg, tl, $urandom_range(0, 1), 5'($urandom_range(0, 25)), 1, 0);
            else if (sel < 84) cyc(0, 0, tg, tl, 1, 5'($urandom_range(0, 25)), $urandom_range(0, 1), 1);
            else if (sel < 92) cyc(0, 1, tg, tl, $urandom_range(0, 1), 5'($urandom_range(0, 25)),
                                   $urandom_range(0, 1), $urandom_range(0, 1));
            else if (sel < 93) cyc(1, $urandom_range(0, 1), tg, tl, 1, 5'd0, 0, 0);
            else cyc(0, 0, tg, tl, 0, 5'd0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/typed_text_buffer.md
# typed_text_buffer

Accumulates the player's keystrokes into the packed 25-character letter string consumed by the text renderer, and scores them against the target phrase. Sits between the keyboard decoder (letter codes 0–25, backspace, clear) and the text display stage. It also reports length, correct-position count, mistyped-key count and a completion pulse to the game controller.

## Interface
- `MAX_LEN`, 25: character slots; packed width is `MAX_LEN*CHAR_W`.
- `CHAR_W`, 5: bits per character code (0 = 'A' … 25 = 'Z').
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse: latch target, clear buffer, enter TYPING.
- `target`  in  125  target phrase, char i at bits `[i*5 +: 5]`.
- `target_len`  in  5  target length; 0 or >25 is treated as 25.
- `key_valid`  in  1  one-cycle letter strobe.
- `key_code`  in  5  letter code; values >25 are ignored.
- `key_bs`  in  1  one-cycle backspace strobe.
- `key_clr`  in  1  one-cycle abort strobe.
- `text`  out  125  typed string, same packing as `target`; unused slots hold `PAD_CODE`.
- `text_len`  out  5  characters currently held.
- `correct_cnt`  out  5  positions i < `text_len` with text[i] == target[i].
- `err_cnt`  out  8  mistyped keystrokes since `start`, saturating at 255.
- `state`  out  2  IDLE=0, TYPING=1, DONE=2.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE → TYPING on `start`.
  - TYPING → DONE when `text_len == tlen && correct_cnt == tlen` after an update.
  - TYPING → IDLE on `key_clr`.
  - DONE → TYPING on `start`; DONE → IDLE on `key_clr`.
- `tlen` is the latched and clamped `target_len`. The target is latched only on `start`; later changes to `target` have no effect.
- Event priority within one cycle: `rst` > `start` > `key_clr` > `key_bs` > `key_valid`. Only the highest-priority event acts.
- Letter and backspace events are honoured only in TYPING and ignored in IDLE and DONE.
- Letter event:
  - If `text_len < tlen`, write code at slot `text_len` and increment `text_len`.
  - Match → `correct_cnt`+1. Mismatch → `err_cnt`+1 (saturating).
  - If `text_len == tlen` (full), the letter is ignored; counters are unchanged.
- Backspace event:
  - If `text_len > 0`, restore slot `text_len-1` to `PAD_CODE` and decrement `text_len`.
  - If the removed char matched the target, decrement `correct_cnt`. `err_cnt` is never decremented.
  - Backspace on an empty buffer is ignored.
- `start` (from any state, including mid-typing): all slots := `PAD_CODE`, `text_len`=0, `correct_cnt`=0, `err_cnt`=0.
- `key_clr`: same clearing; the target latch is retained.
- A full buffer with mismatches stays in TYPING; the player must backspace to correct it.

## Timing
- All outputs are registered. An event sampled at edge N is visible on the outputs after edge N.
- `done` is high for exactly the one cycle following the edge at which `state` becomes DONE. It never re-asserts until a new `start`.
- Back-to-back events on consecutive cycles are all processed; no idle cycle is required.
- Reset values:
  - `text` = all `PAD_CODE`.
  - `text_len`, `correct_cnt`, `err_cnt` = 0.
  - `state` = IDLE; `done` = 0.
  - Target latch = 0; `tlen` = 25.
- Width rules: comparisons use the 5-bit codes exactly. `text_len`/`correct_cnt` never exceed `tlen`. `err_cnt` holds at 255.

## Configuration
- `TYPEBUF_STRICT_EN` defined: a mismatching letter is not stored, and only `err_cnt` increments. Consequently `correct_cnt == text_len` always.
- `TYPEBUF_STRICT_EN` undefined: mismatching letters are stored as described under Operation.

## Structure
- Shared package `typeracer_pkg` holds:
  - `MAX_LEN`, `CHAR_W`, `PAD_CODE` (5'd31).
  - The state enum {IDLE, TYPING, DONE}.
  - The letter-range constant 25, used by the keyboard decoder and display as well.
- One sub-module, `sat_counter` (parameter width, inc/clr inputs), implements `err_cnt`. All remaining logic stays in this block.

## Test plan
- Target "CAT" (2,0,19), len 3; `start`; keys 2,0,19 → `text_len`=3, `correct_cnt`=3, `err_cnt`=0, `state`=DONE, `done` high one cycle.
- Same target; keys 2,1 then backspace then 0,19 → `err_cnt`=1, `correct_cnt`=3, slot 3 and up = 31, DONE reached.
- Fill 25 slots with target_len 0, then one more letter → `text_len` stays 25, extra key ignored.
- Backspace in an empty buffer, and keys while IDLE or with `key_code`=27 → all outputs unchanged.
- `start` and `key_valid` in the same cycle, and `rst` mid-typing → buffer cleared; the key is not stored.
- With `TYPEBUF_STRICT_EN` defined: key 5 against target 'C' → `text_len`=0, `err_cnt`=1.
